// File: rtl/dhaz_scoreboard_pkg.sv
// Shared types for the data-hazard scoreboard: producer class, slot record, select width.
// Plays the role of the Pu_types package; TAG_MAX bounds the tag width of any instance.
package dhaz_scoreboard_pkg;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'd0,
        CLS_MEM   = 2'd1,
        CLS_MUL   = 2'd2,
        CLS_NOFWD = 2'd3
    } prod_class_t;

    localparam int TAG_MAX = 16;

    // Tags narrower than TAG_MAX are zero-extended so every instance shares one slot layout.
    typedef struct packed {
        logic              valid;
        logic [TAG_MAX-1:0] tag;
        prod_class_t       cls;
    } dhaz_slot_t;

    function automatic int sel_w(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/dhaz_slot_pipe.sv
// Shifting slot array of in-flight register writes with masked flush and slot-0 insertion.
// The last slot retires every cycle; empty is registered from the next-state valid bits.
module dhaz_slot_pipe
    import dhaz_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         insert,
    input  dhaz_slot_t                   new_slot,
    input  logic                         flush,
    input  logic [NUM_STAGES-1:0]        flush_mask,
    output dhaz_slot_t [NUM_STAGES-1:0]  slots,
    output logic                         empty
);

    dhaz_slot_t [NUM_STAGES-1:0] slots_nxt;
    logic                        any_valid_nxt;
    logic                        unused_mask;

    // The retiring slot is dropped regardless, so its flush bit has no effect.
    assign unused_mask = flush_mask[NUM_STAGES-1];

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        slots_nxt     = '0;
        any_valid_nxt = 1'b0;
        slots_nxt[0]  = insert ? new_slot : '0;
        for (int i = 1; i < NUM_STAGES; i++) begin
            slots_nxt[i] = slots[i-1];
            if (flush && flush_mask[i-1]) begin
                slots_nxt[i].valid = 1'b0;
            end
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
            any_valid_nxt = any_valid_nxt | slots_nxt[i].valid;
        end
    end

    // NOTE: the slot array is plain flops, not a RAM, so it is reset to clear every valid bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slots <= '0;
            empty <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep all slots shifting off the same old values.
            slots <= slots_nxt;
            empty <= ~any_valid_nxt;
        end
    end

endmodule

// File: rtl/dhaz_scoreboard.sv
// Data-hazard scoreboard: per-port match against in-flight writes, stall and forwarding selects.
// Build option DHAZ_FORWARDING_EN enables forwarding; without it every match stalls until retire.
module dhaz_scoreboard
    import dhaz_scoreboard_pkg::*;
#(
    parameter int  NUM_STAGES   = 4,
    parameter int  NUM_RD_PORTS = 3,
    parameter int  TAG_WIDTH    = 5,
    parameter int  MUL_READY    = 2,
    localparam int SEL_W        = sel_w(NUM_STAGES)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  en,
    input  logic                                  issue_wr,
    input  logic [TAG_WIDTH-1:0]                  issue_tag,
    input  logic [1:0]                            issue_class,
    input  logic [NUM_RD_PORTS-1:0]               rd_en,
    input  logic [NUM_RD_PORTS-1:0][TAG_WIDTH-1:0] rd_tag,
    input  logic                                  flush,
    input  logic [NUM_STAGES-1:0]                 flush_mask,
    output logic                                  hold,
    output logic [NUM_RD_PORTS-1:0][SEL_W-1:0]    fwd_sel,
    output logic                                  empty
);

    dhaz_slot_t [NUM_STAGES-1:0] slots;
    dhaz_slot_t                  new_slot;
    logic                        insert;
    logic [NUM_RD_PORTS-1:0]     conflict;

`ifdef DHAZ_FORWARDING_EN
    logic [NUM_RD_PORTS-1:0]            fwd_ok;
    logic [NUM_RD_PORTS-1:0][SEL_W-1:0] fwd_idx;

    function automatic logic slot_ready(input prod_class_t cls, input int slot);
        case (cls)
            CLS_ALU: return 1'b1;
            CLS_MEM: return slot >= 1;
            CLS_MUL: return slot >= MUL_READY;
            default: return 1'b0;
        endcase
    endfunction
`else
    logic unused_cls;
    assign unused_cls = ^slots;
`endif

    always_comb begin
        new_slot.valid = 1'b1;
        new_slot.tag   = TAG_MAX'(issue_tag);
        new_slot.cls   = prod_class_t'(issue_class);
    end

    assign hold   = en & ~flush & (|conflict);
    assign insert = en & issue_wr & ~hold & ~flush;

    dhaz_slot_pipe #(.NUM_STAGES(NUM_STAGES)) u_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .insert     (insert),
        .new_slot   (new_slot),
        .flush      (flush),
        .flush_mask (flush_mask),
        .slots      (slots),
        .empty      (empty)
    );

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic hit;
`ifdef DHAZ_FORWARDING_EN
        logic             rdy;
        logic [SEL_W-1:0] idx;
`endif
        always_comb begin
            hit = 1'b0;
`ifdef DHAZ_FORWARDING_EN
            rdy = 1'b0;
            idx = '0;
`endif
            // Scan oldest to youngest so the youngest matching slot is the one left standing.
            for (int i = NUM_STAGES - 1; i >= 0; i--) begin
                if (slots[i].valid && slots[i].tag == TAG_MAX'(rd_tag[p])) begin
                    hit = 1'b1;
`ifdef DHAZ_FORWARDING_EN
                    rdy = slot_ready(slots[i].cls, i);
                    idx = SEL_W'(i + 1);
`endif
                end
            end
        end

`ifdef DHAZ_FORWARDING_EN
        assign conflict[p] = rd_en[p] & hit & ~rdy;
        assign fwd_ok[p]   = rd_en[p] & hit & rdy;
        assign fwd_idx[p]  = idx;
`else
        assign conflict[p] = rd_en[p] & hit;
`endif
    end

`ifdef DHAZ_FORWARDING_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_sel <= '0;
        end else begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                fwd_sel[p] <= (fwd_ok[p] && !hold && !flush) ? fwd_idx[p] : '0;
            end
        end
    end
`else
    assign fwd_sel = '0;
`endif

endmodule

// File: doc/dhaz_scoreboard.md
# dhaz_scoreboard

Parametrised data-hazard scoreboard for the integer pipeline. It tracks in-flight register writes in a configurable-depth slot pipeline, with one latency class per producer, and compares every decode read port against it. From this it raises the decode/fetch stall and generates registered forwarding selects that name the exact producing stage. It sits between decode and the bypass network, and generalises fixed-depth, ALU-only GPR tracking to N read ports, N stages, per-class ready stages and pipeline flush.

## Interface
Parameters:
- NUM_STAGES, 4: tracked slots after issue; slot 0 = producer in EX, slot NUM_STAGES-1 = last cycle before register-file write is visible.
- NUM_RD_PORTS, 3: decode read ports checked in parallel.
- TAG_WIDTH, 5: register index width.
- MUL_READY, 2: first slot at which a class-MUL result can be forwarded (1 ≤ MUL_READY < NUM_STAGES).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  scoreboard enable; 0 forces hold=0 and blocks insertion.
- issue_wr  in  1  decoded instruction writes a register.
- issue_tag  in  TAG_WIDTH  destination index.
- issue_class  in  2  Prod_class: ALU=0 (ready slot 0), MEM=1 (ready slot 1), MUL=2 (ready MUL_READY), NOFWD=3 (never forwarded).
- rd_en  in  NUM_RD_PORTS  per-port read request.
- rd_tag  in  NUM_RD_PORTS×TAG_WIDTH  per-port source index.
- flush  in  1  kill request.
- flush_mask  in  NUM_STAGES  slots to invalidate on flush.
- hold  out  1  stall fetch/decode (combinational).
- fwd_sel  out  NUM_RD_PORTS×SEL_W  registered select; 0 = register file, k = slot k-1; SEL_W = $clog2(NUM_STAGES+1).
- empty  out  1  registered; no valid slot (for sync/isync draining).

## Operation
- Slot state: valid, tag, class. Shift every cycle: slot[i+1] ← slot[i]; slot NUM_STAGES-1 retires and is dropped.
- Insert into slot 0 iff en & issue_wr & ~hold & ~flush; otherwise slot 0 ← invalid (bubble).
- Flush: slots whose flush_mask bit is set are invalidated before shifting; this overrides insertion and matching in the same cycle.
- Match per port p: the youngest (lowest-index) valid slot whose tag equals rd_tag[p]. Older matches are shadowed.
- ready(class, slot): ALU slot≥0, MEM slot≥1, MUL slot≥MUL_READY, NOFWD never.
- Port conflict = rd_en[p] & match & ~(forwarding & ready). hold = en & ~flush & OR(conflicts).
- fwd_sel[p] next = matched slot+1 when rd_en[p], the match is ready, and hold=0; else 0. When hold=1, all fwd_sel next = 0.
- Retired writes need no forwarding; the register file provides write-through.
- The same tag in two slots is legal; the youngest wins.

## Timing
- Reset: all slots invalid, fwd_sel=0, empty=1; hold=0 follows combinationally.
- hold is combinational from rd_*/issue state: same-cycle.
- fwd_sel and empty have 1-cycle latency and align with the consumer entering EX.
- Dependent ALU→ALU back-to-back: 0 stall. MEM→use: 1 stall. MUL→use: MUL_READY stalls. NOFWD: stall until retire (NUM_STAGES cycles).
- Reset assertion mid-operation clears all state asynchronously. The first cycle after deassertion behaves as empty.

## Configuration
- DHAZ_FORWARDING_EN defined: behaviour as above.
- DHAZ_FORWARDING_EN undefined: ready() is always false, so any match stalls until retire. fwd_sel is tied to 0 and the select registers are removed.

## Structure
- Pu_types holds Prod_class, the Dhaz_slot struct (valid, tag, class) and the SEL_W function.
- One sub-module, dhaz_slot_pipe: the shifting slot array with flush and insertion. It exports the slot vector.
- Match, priority and ready logic stay in dhaz_scoreboard, in one generate loop per read port.

## Test plan
- ALU issue r5, next cycle read r5 on port 0 → hold=0, fwd_sel[0]=1 the following cycle.
- MEM issue r7, next cycle read r7 → hold=1 for 1 cycle, then fwd_sel=2.
- r3 issued ALU then MEM on consecutive cycles, then read r3 → youngest (MEM, slot 0) wins → 1 stall, fwd_sel=2.
- NOFWD issue r9 with NUM_STAGES=4, read r9 → hold for 4 cycles, then fwd_sel=0; same result with DHAZ_FORWARDING_EN undefined for an ALU producer.
- ALU issue r4, flush with flush_mask=4'b0001 next cycle while reading r4 → hold=0, fwd_sel=0, empty=1 afterwards.
- Assert reset_n=0 with 3 valid slots → empty=1 and fwd_sel=0 immediately; a read of a previously in-flight tag after release → no hold.
